// File: rtl/icache_dm_ro_if.sv
// Processor fetch port and memory line-fill port of the direct-mapped I-cache.
// master = pipeline plus memory (environment side), slave = the cache itself.
// Plain wires only; timing is owned by the cache and its environment.
interface icache_dm_ro_if;
  logic         proc_ren;
  logic         proc_wen;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_dm_ro.sv
// Direct-mapped read-only instruction cache, 4 x 32-bit words per line.
// Latency: hit is combinational (0 cycles); miss stalls for memory latency + 2.
// Backpressure: proc_stall held high from the miss cycle until the filled line is readable.
module icache_dm_ro #(
  parameter int LINE_NUM = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  icache_dm_ro_if.slave  bus
);

  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [27:0]         r_mem_addr;
  logic                r_mem_read;
  logic [LINE_NUM-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [LINE_NUM];
  logic [127:0]        r_data [LINE_NUM];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_fill_idx;
  logic [TAG_W-1:0]    w_fill_tag;
  logic                w_hit;
  logic [127:0]        w_line;
  logic [31:0]         w_word;
  logic                w_fill_done;
  logic                w_unused;

  // Lookup fields come from the live address; fill fields from the latched miss address.
  assign w_idx      = bus.proc_addr[IDX_W+1:2];
  assign w_tag      = bus.proc_addr[29:IDX_W+2];
  assign w_fill_idx = r_mem_addr[IDX_W-1:0];
  assign w_fill_tag = r_mem_addr[27:IDX_W];
  assign w_hit      = bus.proc_ren && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_done = (r_state == S_FETCH) && bus.mem_ready;

  // Write port and write data are meaningless for an instruction cache.
  assign w_unused = ^{bus.proc_wen, bus.proc_wdata};

  // Word select within the indexed line; an invalid line reads as zero.
  always_comb begin
    w_line = r_data[w_idx];
    w_word = 32'd0;
    case (bus.proc_addr[1:0])
      2'd0: w_word = w_line[31:0];
      2'd1: w_word = w_line[63:32];
      2'd2: w_word = w_line[95:64];
      default: w_word = w_line[127:96];
    endcase
  end

  assign bus.proc_rdata = r_valid[w_idx] ? w_word : 32'd0;
  assign bus.proc_stall = (r_state == S_IDLE) ? (bus.proc_ren && !w_hit) : 1'b1;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = 128'd0;

  // Miss-handling FSM: latch the line address, request it, mark the line valid on return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_addr <= 28'd0;
      r_mem_read <= 1'b0;
      r_valid    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.proc_ren && !w_hit) begin
            r_mem_addr <= bus.proc_addr[29:2];
            r_mem_read <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.mem_ready) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_mem_read          <= 1'b0;
            r_state             <= S_FILL;
          end
        end
        S_FILL: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_read <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.mem_rdata;
    end
  end

endmodule
